mean_std_ctrl: RTL and testbench

Frame sequencer for the `mean_std` statistics datapath in the audio-processing chain. It collects one mel frame from a serial coefficient stream into a frame buffer and presents the frozen buffer to `mean_std` with a one-cycle start pulse. It then captures the registered mean/std pair and delivers it to the neural-network side over a ready/valid handshake with backpressure. It also detects malformed frames (wrong `coef_last` position) and resynchronises to the stream.

---
 rtl/mean_std_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mean_std_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_std_ctrl.sv
// -----------------------------------------------------------------------------
// mean_std_ctrl
//
// Frame sequencer for the mean_std statistics datapath. It collects one mel
// frame from a serial coefficient stream into a frame buffer. It then presents
// the frozen buffer to mean_std with a one-cycle start pulse, captures the
// returned mean/std pair, and offers it downstream on a ready/valid slot.
// Frames whose coef_last marker is in the wrong position are reported on
// frame_err, and the sequencer resynchronises to the stream.
//
// Handshake rule used on both the coefficient and the result side:
//   a transfer happens on a rising clk edge where valid && ready are both
//   high. valid does not depend on ready. The sender holds its payload
//   stable while valid is high and ready is low.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   coef_valid     coefficient beat valid
//   coef_data      coefficient value
//   coef_last      final beat of a frame
//   coef_ready     controller accepts a beat (FILL / DROP)
//   ms_valid_in    start pulse to mean_std
//   ms_data        frame buffer, element i at [i*MSIN_DATA_WIDTH +: MSIN_DATA_WIDTH]
//   ms_valid_out   mean_std result valid
//   ms_mean/ms_std mean_std result
//   res_valid      result slot occupied
//   res_ready      downstream accepts the result
//   res_mean/res_std captured result
//   frame_err      one-cycle pulse after a malformed frame's offending beat
//   frame_cnt      number of delivered results, wraps at 16 bits
//   state_dbg      current sequencer state (FILL=0, DROP=1, FIRE=2, WAIT=3)
// -----------------------------------------------------------------------------
module mean_std_ctrl #(
  parameter int MSIN_DATA_WIDTH = 16,
  parameter int MS_ARRAY_WIDTH  = 20,
  parameter int NN_DATA_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      coef_valid,
  input  logic [MSIN_DATA_WIDTH-1:0]                coef_data,
  input  logic                                      coef_last,
  output logic                                      coef_ready,
  output logic                                      ms_valid_in,
  output logic [MSIN_DATA_WIDTH*MS_ARRAY_WIDTH-1:0] ms_data,
  input  logic                                      ms_valid_out,
  input  logic [NN_DATA_WIDTH-1:0]                  ms_mean,
  input  logic [NN_DATA_WIDTH-1:0]                  ms_std,
  output logic                                      res_valid,
  input  logic                                      res_ready,
  output logic [NN_DATA_WIDTH-1:0]                  res_mean,
  output logic [NN_DATA_WIDTH-1:0]                  res_std,
  output logic                                      frame_err,
  output logic [15:0]                               frame_cnt,
  output logic [1:0]                                state_dbg
);

  localparam int IW = $clog2(MS_ARRAY_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(MS_ARRAY_WIDTH - 1);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_DROP = 2'd1,
    S_FIRE = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  state_t                     state_q;
  state_t                     state_d;
  logic [IW-1:0]              idx_q;
  logic [MSIN_DATA_WIDTH-1:0] buf_q [MS_ARRAY_WIDTH];
  logic [15:0]                frame_cnt_q;

  // Decoded controls (output process)
  logic accept;       // beat transferred this edge
  logic fill_accept;  // beat transferred while filling
  logic idx_at_last;  // write pointer on the last buffer slot
  logic slot_free;    // result slot empty or being drained this cycle
  logic capture;      // mean_std result latched this edge
  logic res_hs;       // result transferred downstream this edge

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FILL: begin
        if (accept && idx_at_last) begin
          // Last slot: either a well-formed end of frame, or a frame that is
          // missing its marker and must be skipped up to the next marker.
          state_d = coef_last ? S_FIRE : S_DROP;
        end
      end
      S_DROP: begin
        if (accept && coef_last) begin
          state_d = S_FILL;
        end
      end
      S_FIRE: begin
        if (ms_valid_in) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ms_valid_out) begin
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    coef_ready  = (state_q == S_FILL) || (state_q == S_DROP);
    accept      = coef_valid && coef_ready;
    fill_accept = accept && (state_q == S_FILL);
    idx_at_last = (idx_q == LAST_IDX);
    // The slot frees up in the same cycle that downstream drains it, so a
    // parked frame can launch without an extra bubble.
    slot_free   = !res_valid || res_ready;
    ms_valid_in = (state_q == S_FIRE) && slot_free;
    capture     = (state_q == S_WAIT) && ms_valid_out;
    res_hs      = res_valid && res_ready;
    state_dbg   = state_q;
  end

  // ---------------------------------------------------------------------------
  // Write index, frame buffer and error pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      // A frame is malformed when the marker and the last slot disagree.
      frame_err <= fill_accept && (coef_last != idx_at_last);
      if (fill_accept) begin
        if (coef_last || idx_at_last) begin
          idx_q <= '0;
        end else begin
          idx_q <= idx_q + IW'(1);
        end
      end
    end
  end

  // Beats of a discarded frame are written too. They are don't-care and are
  // overwritten by the next frame before it is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MS_ARRAY_WIDTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (fill_accept) begin
      buf_q[idx_q] <= coef_data;
    end
  end

  always_comb begin
    ms_data = '0;
    for (int i = 0; i < MS_ARRAY_WIDTH; i++) begin
      ms_data[i*MSIN_DATA_WIDTH +: MSIN_DATA_WIDTH] = buf_q[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Result slot and delivered-frame counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid   <= 1'b0;
      res_mean    <= '0;
      res_std     <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (capture) begin
        res_valid <= 1'b1;
        res_mean  <= ms_mean;
        res_std   <= ms_std;
      end else if (res_hs) begin
        res_valid <= 1'b0;
      end
      if (res_hs) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_mean_std_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for mean_std_ctrl. A small behavioural stand-in for mean_std computes
// the integer mean and population standard deviation of the presented buffer
// one clock after the start pulse. Expected results are computed from the
// frames the driver sends and queued in exp_q. A monitor pops exp_q on each
// result handshake.
// -----------------------------------------------------------------------------
module tb_mean_std_ctrl;

  localparam int W  = 16;
  localparam int N  = 20;
  localparam int NW = 16;

  typedef logic [W-1:0] frame_t [N];

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic            coef_valid = 1'b0;
  logic [W-1:0]    coef_data = '0;
  logic            coef_last = 1'b0;
  logic            coef_ready;
  logic            ms_valid_in;
  logic [W*N-1:0]  ms_data;
  logic            ms_valid_out = 1'b0;
  logic [NW-1:0]   ms_mean = '0;
  logic [NW-1:0]   ms_std = '0;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [NW-1:0]   res_mean;
  logic [NW-1:0]   res_std;
  logic            frame_err;
  logic [15:0]     frame_cnt;
  logic [1:0]      state_dbg;

  mean_std_ctrl #(
    .MSIN_DATA_WIDTH(W),
    .MS_ARRAY_WIDTH (N),
    .NN_DATA_WIDTH  (NW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .coef_valid  (coef_valid),
    .coef_data   (coef_data),
    .coef_last   (coef_last),
    .coef_ready  (coef_ready),
    .ms_valid_in (ms_valid_in),
    .ms_data     (ms_data),
    .ms_valid_out(ms_valid_out),
    .ms_mean     (ms_mean),
    .ms_std      (ms_std),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_mean    (res_mean),
    .res_std     (res_std),
    .frame_err   (frame_err),
    .frame_cnt   (frame_cnt),
    .state_dbg   (state_dbg)
  );

  // Scoreboard state
  logic [2*NW-1:0] exp_q[$];
  logic [15:0]     exp_cnt = '0;
  int              checks = 0;
  int              failures = 0;
  int              vin_cnt = 0;
  int              err_cnt = 0;
  int              exp_vin = 0;
  int              exp_err = 0;
  bit              rand_ready_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference statistics: integer mean, population std (floor sqrt).
  function automatic logic [2*NW-1:0] ref_stats(input frame_t f);
    longint sum, mean, var_sum, v, r;
    sum = 0;
    for (int i = 0; i < N; i++) sum += longint'(f[i]);
    mean = sum / N;
    var_sum = 0;
    for (int i = 0; i < N; i++) var_sum += (longint'(f[i]) - mean) * (longint'(f[i]) - mean);
    v = var_sum / N;
    r = 0;
    while ((r + 1) * (r + 1) <= v) r++;
    return {mean[NW-1:0], r[NW-1:0]};
  endfunction

  function automatic frame_t alt_frame(input logic [W-1:0] a, input logic [W-1:0] b);
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = (i % 2 == 0) ? a : b;
    return f;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    for (int i = 0; i < N; i++) f[i] = W'($urandom_range(1, 1000));
    return f;
  endfunction

  // Stand-in for mean_std: register-out, one cycle after the start pulse.
  bit     emu_fire = 1'b0;
  frame_t emu_frame;
  always @(negedge clk) begin
    #2;
    emu_fire = ms_valid_in;
    for (int i = 0; i < N; i++) emu_frame[i] = ms_data[i*W +: W];
  end
  always @(posedge clk) begin
    ms_valid_out <= emu_fire && rst_n;
    if (emu_fire) {ms_mean, ms_std} <= ref_stats(emu_frame);
  end

  // Random downstream backpressure
  always @(negedge clk) begin
    if (rand_ready_en) res_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: samples mid-low-phase, after the driver has settled its inputs.
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      check("frame_cnt_track", 64'(frame_cnt), 64'(exp_cnt));
      if (ms_valid_in) vin_cnt++;
      if (frame_err) err_cnt++;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL result_unexpected: got mean=%0d std=%0d expected none", res_mean, res_std);
        end else begin
          logic [2*NW-1:0] e;
          e = exp_q.pop_front();
          check("res_mean", 64'(res_mean), 64'(e[2*NW-1:NW]));
          check("res_std", 64'(res_std), 64'(e[NW-1:0]));
        end
        exp_cnt = exp_cnt + 16'd1;
      end
    end
  end

  // Driver: called just after a negedge, returns just after the negedge that
  // follows the accepting edge.
  task automatic send_beat(input logic [W-1:0] d, input bit last, input int gap);
    int n;
    coef_valid = 1'b0;
    coef_last  = 1'b0;
    repeat (gap) @(negedge clk);
    coef_valid = 1'b1;
    coef_data  = d;
    coef_last  = last;
    n = 0;
    while (!coef_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout: coef_ready stayed 0 for %0d cycles, expected 1", n);
    end
    @(negedge clk);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  task automatic send_frame(input frame_t f, input int n, input int last_at, input int max_gap);
    for (int i = 0; i < n; i++) begin
      send_beat(f[i], (i == last_at), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    end
  endtask

  task automatic push_good(input frame_t f);
    exp_q.push_back(ref_stats(f));
    exp_vin++;
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t f;
    int     n;

    // ---------------- reset ----------------
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_coef_ready", 64'(coef_ready), 64'd1);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_ms_valid_in", 64'(ms_valid_in), 64'd0);
    @(negedge clk);

    // ---------------- nominal frame ----------------
    res_ready = 1'b0;
    f = alt_frame(16'd2, 16'd6);
    push_good(f);
    send_frame(f, N, N - 1, 0);
    check("nom_vin_t1", 64'(ms_valid_in), 64'd1);
    check("nom_ready_t1", 64'(coef_ready), 64'd0);
    @(negedge clk);
    check("nom_vin_t2", 64'(ms_valid_in), 64'd0);
    check("nom_resv_t2", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("nom_resv_t3", 64'(res_valid), 64'd1);
    check("nom_ready_t3", 64'(coef_ready), 64'd1);
    check("nom_mean", 64'(res_mean), 64'd4);
    check("nom_std", 64'(res_std), 64'd2);

    // ---------------- backpressure ----------------
    f = alt_frame(16'd10, 16'd20);
    push_good(f);
    send_frame(f, N, N - 1, 0);
    repeat (3) begin
      check("bp_vin_parked", 64'(ms_valid_in), 64'd0);
      check("bp_ready_parked", 64'(coef_ready), 64'd0);
      check("bp_mean_held", 64'(res_mean), 64'd4);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    check("bp_vin_release", 64'(ms_valid_in), 64'd1);
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_cnt_1", 64'(frame_cnt), 64'd1);
    check("bp_resv_drained", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("bp_resv_second", 64'(res_valid), 64'd1);
    check("bp_mean_second", 64'(res_mean), 64'd15);
    check("bp_std_second", 64'(res_std), 64'd5);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_cnt_2", 64'(frame_cnt), 64'd2);

    // ---------------- early last ----------------
    send_frame(rand_frame(), 6, 5, 0);
    exp_err++;
    check("early_err_pulse", 64'(frame_err), 64'd1);
    check("early_ready", 64'(coef_ready), 64'd1);
    @(negedge clk);
    check("early_err_clear", 64'(frame_err), 64'd0);
    f = alt_frame(16'd1, 16'd3);
    push_good(f);
    send_frame(f, N, N - 1, 0);
    repeat (4) @(negedge clk);
    check("early_err_cnt", 64'(err_cnt), 64'(exp_err));
    check("early_vin_cnt", 64'(vin_cnt), 64'(exp_vin));

    // ---------------- missing last ----------------
    send_frame(rand_frame(), N, -1, 0);
    exp_err++;
    check("miss_err_pulse", 64'(frame_err), 64'd1);
    @(negedge clk);
    check("miss_err_clear", 64'(frame_err), 64'd0);
    send_frame(rand_frame(), 7, 6, 0);
    check("drop_no_err", 64'(frame_err), 64'd0);
    check("drop_no_vin", 64'(ms_valid_in), 64'd0);
    check("drop_ready", 64'(coef_ready), 64'd1);
    f = rand_frame();
    push_good(f);
    send_frame(f, N, N - 1, 0);
    repeat (4) @(negedge clk);
    check("miss_cnt", 64'(frame_cnt), 64'd4);
    check("miss_err_cnt", 64'(err_cnt), 64'(exp_err));
    check("miss_vin_cnt", 64'(vin_cnt), 64'(exp_vin));

    // ---------------- gapped input, random backpressure ----------------
    rand_ready_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      f = (k == 0) ? alt_frame(16'd2, 16'd6) : rand_frame();
      push_good(f);
      send_frame(f, N, N - 1, 3);
    end
    rand_ready_en = 1'b0;
    res_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gap_drain", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("gap_cnt", 64'(frame_cnt), 64'd10);
    check("gap_vin_cnt", 64'(vin_cnt), 64'(exp_vin));

    // ---------------- counter wrap ----------------
    force dut.frame_cnt_q = 16'hFFFF;
    exp_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    #1;
    check("wrap_preload", 64'(frame_cnt), 64'hFFFF);
    @(negedge clk);
    f = alt_frame(16'd2, 16'd6);
    push_good(f);
    send_frame(f, N, N - 1, 0);
    repeat (4) @(negedge clk);
    check("wrap_zero", 64'(frame_cnt), 64'd0);

    // ---------------- reset mid-stream ----------------
    res_ready = 1'b0;
    f = rand_frame();
    push_good(f);
    send_frame(f, N, N - 1, 0);
    repeat (3) @(negedge clk);
    check("pre_rst_resv", 64'(res_valid), 64'd1);
    send_frame(rand_frame(), 8, -1, 0);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = '0;
    #1;
    check("mid_rst_coef_ready", 64'(coef_ready), 64'd1);
    check("mid_rst_vin", 64'(ms_valid_in), 64'd0);
    check("mid_rst_resv", 64'(res_valid), 64'd0);
    check("mid_rst_mean", 64'(res_mean), 64'd0);
    check("mid_rst_std", 64'(res_std), 64'd0);
    check("mid_rst_err", 64'(frame_err), 64'd0);
    check("mid_rst_ms_data_nz", 64'(ms_data != '0), 64'd0);
    check("mid_rst_cnt", 64'(frame_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 64'(coef_ready), 64'd1);
    check("post_rst_cnt", 64'(frame_cnt), 64'd0);
    @(negedge clk);

    // ---------------- recovery frame ----------------
    res_ready = 1'b1;
    f = alt_frame(16'd2, 16'd6);
    push_good(f);
    send_frame(f, N, N - 1, 0);
    repeat (5) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_cnt", 64'(frame_cnt), 64'd1);
    check("final_vin_cnt", 64'(vin_cnt), 64'(exp_vin));
    check("final_err_cnt", 64'(err_cnt), 64'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
